prog_loader: RTL and testbench
==============================

// Module: prog_loader
// PURPOSE
//  Upstream launcher for the single-cycle 9-bit core: accepts a program as a valid/ready stream of
//  9-bit instruction words, writes them into the writable instruction memory from address 0, then
//  releases the core's reset, and counts run cycles until the core raises done or a timeout fires.
//  The launcher holds the core in reset at all times outside RUN.
// PARAMETERS
//  IW        9          instruction word width
//  AW        12         instruction address width (matches core PC)
//  DEPTH     4096       instruction memory depth in words (<= 2**AW)
//  CW        32         cycle counter width
//  TIMEOUT   1000000    max RUN cycles before abort (must be < 2**CW)
//  RST_CYC   2          cycles cpu_reset stays asserted after load before RUN
// PORTS
//  clk          in   1   clock; everything is on its rising edge
//  reset        in   1   synchronous, active-low reset
//  start        in   1   1-cycle pulse: begin a new load (ignored in LOAD/ARM/RUN)
//  in_valid     in   1   stream word valid
//  in_ready     out  1   loader can accept a word
//  in_data      in   IW  instruction word
//  in_last      in   1   marks final word of program
//  imem_we      out  1   instruction memory write strobe
//  imem_addr    out  AW  instruction memory write address
//  imem_wdata   out  IW  instruction memory write data
//  cpu_reset    out  1   active-high reset to the core
//  cpu_done     in   1   core done flag (level)
//  busy         out  1   high in LOAD, ARM, RUN
//  run_done     out  1   sticky: last run ended by cpu_done
//  timeout      out  1   sticky: last run hit TIMEOUT
//  load_err     out  1   sticky: program exceeded DEPTH words
//  cycle_count  out  CW  RUN cycles of last/current run
//  checksum     out  IW  (CHECKSUM_EN only) XOR of all accepted words
// BEHAVIOUR
//  Reset (reset=0): state=IDLE; in_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, cpu_reset=1,
//   busy=0, run_done=0, timeout=0, load_err=0, cycle_count=0, checksum=0. Reset mid-run aborts at once.
//  States: IDLE, LOAD, ARM, RUN, DONE, ERR.
//  IDLE/DONE/ERR: cpu_reset=1, in_ready=0; start -> LOAD, clears sticky flags, cycle_count, addr, checksum.
//  LOAD: in_ready=1. Accepted beat (in_valid&in_ready) registers imem_we=1, imem_addr=addr,
//   imem_wdata=in_data next cycle (1-cycle write latency); addr increments.
//   Beat with in_last -> ARM. Beat at addr==DEPTH-1 without in_last -> ERR, load_err=1.
//   Beat at addr==DEPTH-1 with in_last is legal -> ARM. No beat: stay, no write.
//  ARM: in_ready=0, cpu_reset=1 for exactly RST_CYC cycles (covers the final write landing), then RUN.
//  RUN: cpu_reset=0; cycle_count increments each cycle in RUN (first RUN cycle -> 1).
//   cpu_done=1 -> DONE, run_done=1, cpu_reset=1 next cycle; cycle_count frozen at value incl. that cycle.
//   cycle_count==TIMEOUT without done -> ERR, timeout=1. Simultaneous done and TIMEOUT: done wins.
//  cycle_count saturates, never wraps. start in LOAD/ARM/RUN is ignored.
// CONFIGURATION
//  CHECKSUM_EN defined: checksum port exists; each accepted beat does checksum ^= in_data; cleared on start.
//  CHECKSUM_EN undefined: no checksum port, no checksum logic; all other behaviour identical.
// STRUCTURE
//  Package loader_pkg: state enum ld_state_t {IDLE,LOAD,ARM,RUN,DONE,ERR}, IW/AW defaults, instr_t
//  (logic [8:0]) and iaddr_t (logic [11:0]) typedefs.
//  One sub-module: ld_cycle_counter (saturating CW-bit counter with clr/en, terminal-count compare).
//  FSM, address counter, write register and flags live in prog_loader.
// TESTING
//  1 start, stream 4 words 0x101,0x0AA,0x155,0x1FF (last on 4th) -> writes at addr 0..3 one cycle after
//    each beat, ARM 2 cycles, then cpu_reset falls; checksum=0x1FF^0x155^0x0AA^0x101.
//  2 in RUN assert cpu_done on the 10th RUN cycle -> run_done=1, cycle_count=10, cpu_reset=1, busy=0.
//  3 TIMEOUT=50, never assert done -> ERR after 50 RUN cycles, timeout=1, cycle_count=50.
//  4 DEPTH=8, stream 9 words, no last -> 8 writes (addr 0..7), load_err=1 after 8th, no 9th accept.
//  5 in_valid gaps/bubbles during LOAD -> no imem_we on idle cycles, addresses stay contiguous.
//  6 reset=0 during RUN at cycle 5 -> next cycle IDLE, cpu_reset=1, all flags and count 0; start ignored in RUN.

Source files
------------

// File: rtl/loader_pkg.sv
// Shared types for the program loader.
// Contents: the FSM state enum, the default instruction and address widths,
// and the instruction word and instruction address typedefs.
package loader_pkg;
  localparam int IW_DEF = 9;
  localparam int AW_DEF = 12;

  typedef logic [IW_DEF-1:0] instr_t;
  typedef logic [AW_DEF-1:0] iaddr_t;

  typedef enum logic [2:0] {IDLE, LOAD, ARM, RUN, DONE, ERR} ld_state_t;
endpackage

// File: rtl/ld_cycle_counter.sv
// Saturating run-cycle counter with a terminal-count compare.
// Ports:
//   clk      in  rising-edge clock
//   reset    in  synchronous active-low reset
//   clr      in  synchronous clear (a new load is starting)
//   en       in  count this cycle
//   count    out current count; holds at all-ones and never wraps
//   at_term  out count equals TERM
module ld_cycle_counter #(
  parameter int            CW   = 32,
  parameter logic [CW-1:0] TERM = '1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clr,
  input  logic          en,
  output logic [CW-1:0] count,
  output logic          at_term
);
  always_ff @(posedge clk) begin
    if (!reset || clr)
      count <= '0;
    else if (en && count != '1)
      count <= count + 1'b1;
  end

  assign at_term = (count == TERM);
endmodule

// File: rtl/prog_loader.sv
// Program loader / launcher for the 9-bit core.
// It takes a valid/ready stream of instruction words and writes them into
// instruction memory starting at address 0. It then holds the core in reset
// for RST_CYC cycles, releases reset, and counts run cycles until cpu_done
// rises or TIMEOUT is reached. The core is held in reset in every state
// except RUN.
// Optional feature: define CHECKSUM_EN to add the checksum port, which is
// the XOR of every accepted word.
// Ports:
//   clk, reset                        clock; synchronous active-low reset
//   start                             1-cycle pulse that begins a load (IDLE/DONE/ERR only)
//   in_valid/in_ready/in_data/in_last instruction stream
//   imem_we/imem_addr/imem_wdata      registered memory write port
//   cpu_reset                         active-high reset to the core
//   cpu_done                          level done flag from the core
//   busy                              high in LOAD, ARM and RUN
//   run_done/timeout/load_err         sticky result flags of the last run
//   cycle_count                       RUN cycles of the last or current run
//   checksum                          XOR of accepted words (CHECKSUM_EN only)
module prog_loader
  import loader_pkg::*;
#(
  parameter int IW      = IW_DEF,
  parameter int AW      = AW_DEF,
  parameter int DEPTH   = 4096,
  parameter int CW      = 32,
  parameter int TIMEOUT = 1000000,
  parameter int RST_CYC = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [IW-1:0] in_data,
  input  logic          in_last,
  output logic          imem_we,
  output logic [AW-1:0] imem_addr,
  output logic [IW-1:0] imem_wdata,
  output logic          cpu_reset,
  input  logic          cpu_done,
  output logic          busy,
  output logic          run_done,
  output logic          timeout,
  output logic          load_err,
  output logic [CW-1:0] cycle_count
`ifdef CHECKSUM_EN
  ,
  output logic [IW-1:0] checksum
`endif
);
  localparam int            ACW      = (RST_CYC > 1) ? $clog2(RST_CYC) : 1;
  localparam logic [ACW-1:0] ARM_LAST = ACW'(RST_CYC - 1);
  localparam logic [AW-1:0]  LAST_SLOT = AW'(DEPTH - 1);
  // The timeout fires on the RUN cycle that brings the count up to TIMEOUT.
  localparam logic [CW-1:0]  TERM     = CW'(TIMEOUT - 1);

  ld_state_t      state, state_n;
  logic [AW-1:0]  addr;
  logic [ACW-1:0] arm_cnt;
  logic           accept, launch, at_term;

  assign accept = (state == LOAD) && in_valid;

  // state register
  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_n;
  end

  // next state and state-decoded outputs
  always_comb begin
    state_n   = state;
    launch    = 1'b0;
    in_ready  = 1'b0;
    cpu_reset = 1'b1;
    busy      = 1'b0;
    case (state)
      IDLE, DONE, ERR: begin
        if (start) begin
          launch  = 1'b1;
          state_n = LOAD;
        end
      end
      LOAD: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (accept) begin
          if (in_last)                 state_n = ARM;
          else if (addr == LAST_SLOT)  state_n = ERR;
        end
      end
      ARM: begin
        busy = 1'b1;
        if (arm_cnt == ARM_LAST) state_n = RUN;
      end
      RUN: begin
        busy      = 1'b1;
        cpu_reset = 1'b0;
        // done has priority over a timeout in the same cycle
        if (cpu_done)     state_n = DONE;
        else if (at_term) state_n = ERR;
      end
      default: state_n = IDLE;
    endcase
  end

  // address counter, write register, arm timer, sticky flags
  always_ff @(posedge clk) begin
    if (!reset) begin
      addr       <= '0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      arm_cnt    <= '0;
      run_done   <= 1'b0;
      timeout    <= 1'b0;
      load_err   <= 1'b0;
    end else begin
      imem_we <= accept;
      arm_cnt <= (state == ARM) ? arm_cnt + 1'b1 : '0;
      if (launch) begin
        addr     <= '0;
        run_done <= 1'b0;
        timeout  <= 1'b0;
        load_err <= 1'b0;
      end
      if (accept) begin
        imem_addr  <= addr;
        imem_wdata <= in_data;
        addr       <= addr + 1'b1;
        if (!in_last && addr == LAST_SLOT) load_err <= 1'b1;
      end
      if (state == RUN) begin
        if (cpu_done)     run_done <= 1'b1;
        else if (at_term) timeout  <= 1'b1;
      end
    end
  end

`ifdef CHECKSUM_EN
  always_ff @(posedge clk) begin
    if (!reset || launch) checksum <= '0;
    else if (accept)      checksum <= checksum ^ in_data;
  end
`endif

  ld_cycle_counter #(.CW(CW), .TERM(TERM)) u_cyc (
    .clk     (clk),
    .reset   (reset),
    .clr     (launch),
    .en      (state == RUN),
    .count   (cycle_count),
    .at_term (at_term)
  );
endmodule

// File: tb/tb_prog_loader.sv
// Testbench for prog_loader, built with DEPTH=8 and TIMEOUT=50. Stimulus
// is directed and randomized. Expected values come from a stream-level
// model: a queue of accepted words, a running XOR, and the number of RUN
// cycles implied by the done/timeout rules.
module tb_prog_loader;
  import loader_pkg::*;

  localparam int DEPTH = 8;
  localparam int TO    = 50;

  logic        clk = 0, reset = 0, start = 0, in_valid = 0, in_last = 0, cpu_done = 0;
  instr_t      in_data = '0;
  logic        in_ready, imem_we, cpu_reset, busy, run_done, timeout, load_err;
  iaddr_t      imem_addr;
  instr_t      imem_wdata;
  logic [31:0] cycle_count;
`ifdef CHECKSUM_EN
  instr_t      checksum;
`endif

  prog_loader #(.DEPTH(DEPTH), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_last(in_last), .imem_we(imem_we), .imem_addr(imem_addr),
    .imem_wdata(imem_wdata), .cpu_reset(cpu_reset), .cpu_done(cpu_done), .busy(busy),
    .run_done(run_done), .timeout(timeout), .load_err(load_err), .cycle_count(cycle_count)
`ifdef CHECKSUM_EN
    , .checksum(checksum)
`endif
  );

  always #5 clk = ~clk;

  int     checks = 0, errors = 0;
  // model state
  bit     m_ready = 0;     // loader expected to accept this cycle
  bit     mon_en  = 0;
  bit     prev_beat = 0;
  instr_t prev_data = '0;
  int     exp_addr = 0, wr_cnt = 0;
  instr_t m_sum = '0;
  instr_t prog[$];

  task automatic chk(input logic [31:0] obs, input logic [31:0] exp, input string tag);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  // Every beat must produce exactly one write on the next cycle, at the next
  // contiguous address, and no write may appear on any other cycle.
  always @(negedge clk) begin
    if (mon_en) begin
      chk(imem_we, prev_beat, "imem_we");
      if (prev_beat) begin
        chk(imem_addr, exp_addr, "imem_addr");
        chk(imem_wdata, prev_data, "imem_wdata");
        exp_addr++;
        wr_cnt++;
      end
    end
    prev_beat = in_valid && m_ready && reset;
    prev_data = in_data;
  end

  task automatic chk_idle_reset(input string tag);
    chk(in_ready, 0, {tag, "_in_ready"});
    chk(imem_we, 0, {tag, "_imem_we"});
    chk(imem_addr, 0, {tag, "_imem_addr"});
    chk(imem_wdata, 0, {tag, "_imem_wdata"});
    chk(cpu_reset, 1, {tag, "_cpu_reset"});
    chk(busy, 0, {tag, "_busy"});
    chk(run_done, 0, {tag, "_run_done"});
    chk(timeout, 0, {tag, "_timeout"});
    chk(load_err, 0, {tag, "_load_err"});
    chk(cycle_count, 0, {tag, "_cycle_count"});
  endtask

  // Stream prog[] with bubbles (gap = percent idle). When with_last is
  // clear, the last word carries no in_last. Returns with the bench in the
  // cycle just after the final accepted beat.
  task automatic do_load(input bit with_last, input int gap);
    int acc = 0, guard = 0;
    int n = prog.size();
    start = 1; exp_addr = 0; wr_cnt = 0; m_sum = '0;
    step(); start = 0;
    m_ready = 1;
    chk(busy, 1, "load_busy");
    chk(run_done, 0, "load_clr_run_done");
    chk(timeout, 0, "load_clr_timeout");
    chk(load_err, 0, "load_clr_load_err");
    chk(cycle_count, 0, "load_clr_count");
    while (acc < n && m_ready && guard < 400) begin
      chk(in_ready, 1, "load_in_ready");
      chk(cpu_reset, 1, "load_cpu_reset");
      in_valid = ($urandom_range(99) >= gap);
      in_data  = prog[acc];
      in_last  = with_last && (acc == n - 1);
      step(); guard++;
      if (in_valid) begin
        m_sum ^= prog[acc];
        acc++;
        if (in_last || acc == DEPTH) m_ready = 0;
      end
    end
    in_valid = 0; in_last = 0;
    if (guard >= 400) chk(0, 1, "load_guard");
  endtask

  task automatic arm_check(input int nwords);
    chk(cpu_reset, 1, "arm1_cpu_reset");
    chk(busy, 1, "arm1_busy");
    chk(in_ready, 0, "arm1_in_ready");
    step();
    chk(cpu_reset, 1, "arm2_cpu_reset");
    chk(wr_cnt, nwords, "write_count");
`ifdef CHECKSUM_EN
    chk(checksum, m_sum, "checksum");
`endif
    step();
    chk(cpu_reset, 0, "run_release");
  endtask

  // Bench sits in RUN cycle 1. done_at/start_at/rst_at pick the RUN cycle
  // (1-based) for cpu_done, a stray start pulse, and reset; 0 means never.
  task automatic do_run(input int done_at, input int start_at, input int rst_at);
    for (int k = 1; k <= TO; k++) begin
      chk(cpu_reset, 0, "run_cpu_reset");
      chk(busy, 1, "run_busy");
      chk(cycle_count, k - 1, "run_count");
      cpu_done = (k == done_at);
      start    = (k == start_at);
      reset    = (k != rst_at);
      step();
      cpu_done = 0; start = 0; reset = 1;
      if (k == rst_at) begin
        chk(dut.state, IDLE, "rst_state");
        chk_idle_reset("midrun_rst");
        return;
      end
      if (k == done_at) begin
        chk(run_done, 1, "done_run_done");
        chk(timeout, 0, "done_timeout");
        chk(cycle_count, k, "done_count");
        chk(cpu_reset, 1, "done_cpu_reset");
        chk(busy, 0, "done_busy");
        cpu_done = 1'($urandom_range(1));
        step(); cpu_done = 0;
        chk(run_done, 1, "done_sticky");
        chk(cycle_count, k, "done_frozen");
        return;
      end
    end
    chk(timeout, 1, "to_timeout");
    chk(run_done, 0, "to_run_done");
    chk(cycle_count, TO, "to_count");
    chk(busy, 0, "to_busy");
    chk(cpu_reset, 1, "to_cpu_reset");
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog observed=hang expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    step(); step(); step();
    chk_idle_reset("reset");
    reset = 1; mon_en = 1;
    step();
    chk_idle_reset("idle");

    // 1: four fixed words, ARM timing, checksum
    prog = '{9'h101, 9'h0AA, 9'h155, 9'h1FF};
    do_load(1, 0);
    arm_check(4);
    // 2: done on 10th RUN cycle; stray start on cycle 3 must be ignored
    do_run(10, 3, 0);

    // 3: never done -> timeout after 50 cycles
    prog = '{9'h03C};
    do_load(1, 30);
    arm_check(1);
    do_run(0, 0, 0);

    // done and timeout in the same cycle: done wins
    prog = '{9'h1A5, 9'h05A};
    do_load(1, 0);
    arm_check(2);
    do_run(TO, 0, 0);

    // 4: overflow, nine words without last
    prog.delete();
    for (int j = 0; j < 9; j++) prog.push_back(instr_t'($urandom_range(511)));
    do_load(0, 20);
    chk(load_err, 1, "ovf_load_err");
    chk(busy, 0, "ovf_busy");
    chk(in_ready, 0, "ovf_in_ready");
    in_valid = 1; in_data = prog[8];
    step(); step();
    in_valid = 0;
    chk(wr_cnt, DEPTH, "ovf_write_count");
    chk(load_err, 1, "ovf_sticky");

    // full-depth program with last on the final slot is legal
    prog.delete();
    for (int j = 0; j < DEPTH; j++) prog.push_back(instr_t'($urandom_range(511)));
    do_load(1, 0);
    chk(load_err, 0, "full_no_err");
    arm_check(DEPTH);
    do_run(7, 0, 0);

    // 5 + random: bubbles, random lengths and run lengths
    for (int it = 0; it < 6; it++) begin
      int n = $urandom_range(1, DEPTH);
      prog.delete();
      for (int j = 0; j < n; j++) prog.push_back(instr_t'($urandom_range(511)));
      do_load(1, $urandom_range(10, 60));
      arm_check(n);
      do_run($urandom_range(1, TO + 5), 0, 0);
    end

    // 6: reset at RUN cycle 5 after a start pulse at cycle 3
    prog = '{9'h111, 9'h022};
    do_load(1, 0);
    arm_check(2);
    do_run(0, 3, 5);
    step();
    chk_idle_reset("post_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
